// File: rtl/lcd_req_arb.sv
// Round-robin scheduler sharing one start/done LCD display path among N_REQ requesters.
// One pending value per requester, forced inter-transaction gap, done timeout, optional refresh.
module lcd_req_arb #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 2,
  parameter int REFRESH_CYC = 0
) (
  input  logic                       I_CLK,
  input  logic                       I_RSTF,
  input  logic [N_REQ-1:0]           I_REQ,
  input  logic [32*N_REQ-1:0]        I_REQ_DATA,
  output logic [N_REQ-1:0]           O_GNT,
  output logic [N_REQ-1:0]           O_REQ_DONE,
  output logic [N_REQ-1:0]           O_DROP,
  output logic                       O_LCD_START,
  output logic [31:0]                O_LCD_DATA,
  input  logic                       I_LCD_DONE,
  output logic [$clog2(N_REQ)-1:0]   O_SEL,
  output logic                       O_BUSY,
  output logic                       O_TIMEOUT
);

  localparam int SW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int RW = $clog2(REFRESH_CYC + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t          state;
  logic [N_REQ-1:0] pend;
  logic [31:0]     pdata [N_REQ];
  logic [31:0]     req_w [N_REQ];
  logic [SW-1:0]   last;
  logic            is_ref;
  logic            shown;
  logic [TW-1:0]   to_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [RW-1:0]   ref_cnt;

  logic [SW-1:0]   sel_c;
  logic [SW-1:0]   cand;
  logic            sel_ok;
  logic [31:0]     issue_data;
  logic            clr_now;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_w[i] = I_REQ_DATA[32*i +: 32];
  end

  // Walk downward from the farthest candidate so the nearest one after `last` wins.
  always_comb begin
    sel_c  = '0;
    sel_ok = 1'b0;
    cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = SW'((int'(last) + k) % N_REQ);
      if (pend[cand]) begin
        sel_c  = cand;
        sel_ok = 1'b1;
      end
    end
  end

  // A request landing in the select cycle is forwarded so the newest value is the one shown.
  assign issue_data = I_REQ[sel_c] ? req_w[sel_c] : pdata[sel_c];
  assign clr_now    = (state == S_ISSUE) && !is_ref;

  always_ff @(posedge I_CLK) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (I_REQ[i]) pdata[i] <= req_w[i];
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTF) begin
      state       <= S_IDLE;
      pend        <= '0;
      last        <= SW'(N_REQ - 1);
      is_ref      <= 1'b0;
      shown       <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      ref_cnt     <= '0;
      O_GNT       <= '0;
      O_REQ_DONE  <= '0;
      O_DROP      <= '0;
      O_LCD_START <= 1'b0;
      O_LCD_DATA  <= '0;
      O_SEL       <= '0;
      O_BUSY      <= 1'b0;
      O_TIMEOUT   <= 1'b0;
    end else begin
      O_GNT       <= '0;
      O_REQ_DONE  <= '0;
      O_DROP      <= '0;
      O_LCD_START <= 1'b0;

      // A new request beats the grant-time clear of the same slot and is not a drop.
      for (int i = 0; i < N_REQ; i++) begin
        if (I_REQ[i]) begin
          pend[i] <= 1'b1;
          if (pend[i] && !(clr_now && O_SEL == SW'(i))) O_DROP[i] <= 1'b1;
        end else if (clr_now && O_SEL == SW'(i)) begin
          pend[i] <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (sel_ok) begin
            state       <= S_ISSUE;
            O_SEL       <= sel_c;
            O_LCD_DATA  <= issue_data;
            O_LCD_START <= 1'b1;
            O_GNT       <= N_REQ'(1) << sel_c;
            O_BUSY      <= 1'b1;
            is_ref      <= 1'b0;
            ref_cnt     <= '0;
          end else if (REFRESH_CYC != 0 && shown && ref_cnt == RW'(REFRESH_CYC - 1)) begin
            state       <= S_ISSUE;
            O_LCD_START <= 1'b1;
            O_BUSY      <= 1'b1;
            is_ref      <= 1'b1;
            ref_cnt     <= '0;
          end else if (REFRESH_CYC != 0 && shown) begin
            ref_cnt <= ref_cnt + RW'(1);
          end
        end
        S_ISSUE: begin
          state  <= S_WAIT;
          to_cnt <= '0;
          if (!is_ref) begin
            last  <= O_SEL;
            shown <= 1'b1;
          end
        end
        S_WAIT: begin
          if (I_LCD_DONE) begin
            state   <= S_GAP;
            gap_cnt <= '0;
            if (!is_ref) O_REQ_DONE <= N_REQ'(1) << O_SEL;
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= S_GAP;
            gap_cnt   <= '0;
            O_TIMEOUT <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state  <= S_IDLE;
            O_BUSY <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_req_arb.sv
// Directed bench for lcd_req_arb: cycle table for basic/round-robin flow plus corner-case sequences.
module tb_lcd_req_arb;

  logic         clk = 1'b0;
  logic         rstf;
  logic [3:0]   req;
  logic [127:0] rdata;
  logic         done;
  logic [3:0]   gnt, rdone, drop;
  logic         start, busy, tmo;
  logic [31:0]  ldata;
  logic [1:0]   sel;

  int total = 0;
  int bad   = 0;

  lcd_req_arb #(.N_REQ(4), .TIMEOUT_CYC(16), .GAP_CYC(2), .REFRESH_CYC(20)) dut (
    .I_CLK(clk), .I_RSTF(rstf), .I_REQ(req), .I_REQ_DATA(rdata),
    .O_GNT(gnt), .O_REQ_DONE(rdone), .O_DROP(drop),
    .O_LCD_START(start), .O_LCD_DATA(ldata), .I_LCD_DONE(done),
    .O_SEL(sel), .O_BUSY(busy), .O_TIMEOUT(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rstf;
    logic [3:0]   req;
    logic [127:0] data;
    logic         done;
    logic [3:0]   gnt;
    logic         start;
    logic [3:0]   rdone;
    logic         busy;
    logic         chkd;
    logic [31:0]  ldata;
    logic [1:0]   sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [127:0] d, logic dn,
                              logic [3:0] g, logic s, logic [3:0] rd, logic b,
                              logic cd, logic [31:0] ld, logic [1:0] sl);
    vec_t v;
    v.rstf = r; v.req = q; v.data = d; v.done = dn;
    v.gnt = g; v.start = s; v.rdone = rd; v.busy = b;
    v.chkd = cd; v.ldata = ld; v.sel = sl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req  = '0;
    done = 1'b0;
    rstf = 1'b1;
  endtask

  task automatic rq(input int i, input logic [31:0] d);
    req[i] = 1'b1;
    rdata[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    rstf = 1'b0;
    tick();
  endtask

  initial begin
    rstf = 1'b0; req = '0; rdata = '0; done = 1'b0;

    // basic transaction (rows 0-14), reset, then four-way round robin (rows 15-36)
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0100, {32'h0, 32'h1234ABCD, 64'h0}, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'b0100, 1, 0, 1, 1, 32'h1234ABCD, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0100, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234ABCD, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234ABCD, 2));
    tbl.push_back(mk(1, 4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(1, 0, 0, 0, 4'(1 << k), 1, 0, 1, 1, 32'hA0 + k, 2'(k)));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'(1 << k), 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0 + k, 2'(k)));
    end

    repeat (2) @(posedge clk);
    #1;
    rstf = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      rstf = tbl[i].rstf; req = tbl[i].req; rdata = tbl[i].data; done = tbl[i].done;
      chk($sformatf("row%0d gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("row%0d start", i), start, tbl[i].start);
      chk($sformatf("row%0d req_done", i), rdone, tbl[i].rdone);
      chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("row%0d drop", i), drop, 0);
      chk($sformatf("row%0d timeout", i), tmo, 0);
      if (tbl[i].chkd) begin
        chk($sformatf("row%0d lcd_data", i), ldata, tbl[i].ldata);
        chk($sformatf("row%0d sel", i), sel, tbl[i].sel);
      end
      tick();
    end

    // overwrite while pending, then a request during the ISSUE cycle of the same requester
    do_reset();
    rq(0, 32'h10); tick(); tick();
    chk("A gnt0", {start, gnt}, {1'b1, 4'b0001});
    chk("A data10", ldata, 32'h10);
    tick();
    rq(1, 32'h11); tick();
    rq(1, 32'h22); chk("A no drop first", drop, 0); tick();
    chk("A drop1", drop, 4'b0010); tick();
    done = 1'b1; tick();
    chk("A req_done0", rdone, 4'b0001); tick(); tick(); tick();
    chk("A gnt1", {start, gnt}, {1'b1, 4'b0010});
    chk("A data22", ldata, 32'h22);
    rq(1, 32'h33); tick();
    chk("A issue req no drop", drop, 0);
    done = 1'b1; tick();
    chk("A req_done1", rdone, 4'b0010); tick(); tick(); tick();
    chk("A regrant1", {start, gnt}, {1'b1, 4'b0010});
    chk("A data33", ldata, 32'h33);
    chk("A no drop end", drop, 0);

    // done never returns: abort after 16 WAIT cycles, pending request still served
    do_reset();
    rq(0, 32'h55); tick(); tick();
    chk("B gnt0", {start, gnt}, {1'b1, 4'b0001});
    tick();
    for (int c = 3; c <= 18; c++) begin
      if (c == 10) rq(3, 32'h77);
      chk($sformatf("B timeout clear c%0d", c), tmo, 0);
      chk($sformatf("B no req_done c%0d", c), rdone, 0);
      chk($sformatf("B busy c%0d", c), busy, 1);
      tick();
    end
    chk("B timeout set", tmo, 1);
    chk("B no req_done abort", rdone, 0);
    tick(); tick();
    chk("B idle after gap", busy, 0);
    tick();
    chk("B gnt3", {start, gnt}, {1'b1, 4'b1000});
    chk("B data77", ldata, 32'h77);
    tick();
    done = 1'b1; tick();
    chk("B req_done3", rdone, 4'b1000);
    chk("B timeout sticky", tmo, 1);

    // periodic refresh of the last value, and a request that preempts it
    do_reset();
    rq(2, 32'hBEEF); tick(); tick();
    chk("C gnt2", {start, gnt}, {1'b1, 4'b0100});
    tick();
    done = 1'b1; tick();
    chk("C req_done2", rdone, 4'b0100); tick(); tick();
    for (int c = 6; c <= 25; c++) begin
      chk($sformatf("C no early refresh c%0d", c), start, 0);
      tick();
    end
    chk("C refresh start", start, 1);
    chk("C refresh no gnt", gnt, 0);
    chk("C refresh data", ldata, 32'hBEEF);
    chk("C refresh sel", sel, 2);
    tick();
    done = 1'b1; tick();
    chk("C refresh no req_done", rdone, 0); tick(); tick();
    for (int c = 30; c <= 41; c++) begin
      if (c == 40) rq(1, 32'hCAFE);
      chk($sformatf("C quiet c%0d", c), start, 0);
      tick();
    end
    chk("C preempt gnt1", {start, gnt}, {1'b1, 4'b0010});
    chk("C preempt data", ldata, 32'hCAFE);
    tick();
    done = 1'b1; tick();
    chk("C req_done1", rdone, 4'b0010); tick(); tick();
    for (int c = 46; c <= 65; c++) begin
      chk($sformatf("C no early refresh2 c%0d", c), start, 0);
      tick();
    end
    chk("C refresh2 start", start, 1);
    chk("C refresh2 no gnt", gnt, 0);
    chk("C refresh2 data", ldata, 32'hCAFE);
    chk("C refresh2 sel", sel, 1);

    // reset while waiting with two values pending
    do_reset();
    rq(0, 32'h1); tick(); tick(); tick();
    rq(1, 32'h21); rq(2, 32'h31); tick();
    rstf = 1'b0; tick();
    chk("D rst gnt", gnt, 0);
    chk("D rst start", start, 0);
    chk("D rst req_done", rdone, 0);
    chk("D rst drop", drop, 0);
    chk("D rst busy", busy, 0);
    chk("D rst timeout", tmo, 0);
    chk("D rst data", ldata, 0);
    chk("D rst sel", sel, 0);
    done = 1'b1; tick();
    for (int c = 6; c <= 15; c++) begin
      chk($sformatf("D no grant c%0d", c), {start, gnt}, 0);
      chk($sformatf("D idle c%0d", c), busy, 0);
      tick();
    end
    rq(3, 32'h99); tick(); tick();
    chk("D gnt3", {start, gnt}, {1'b1, 4'b1000});
    chk("D data99", ldata, 32'h99);
    chk("D sel3", sel, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_req_arb.md
# lcd_req_arb

Round-robin arbiter and scheduler that shares the single 16x2 character LCD display path (`lcd_if`, a start/done controlled register-data display) between several requesters. Each requester posts a 32-bit value to be shown. The arbiter buffers one pending value per requester and issues them to the LCD path one at a time. It enforces a minimum gap between transactions, guards each transaction with a done timeout, and can optionally refresh the last shown value periodically. It sits between the system status sources and the LCD interface block.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 1024: cycles allowed in WAIT for `I_LCD_DONE` before abort, >= 2.
- `GAP_CYC`, 2: idle cycles forced after each transaction, >= 1.
- `REFRESH_CYC`, 0: idle cycles after which the last value is re-issued; 0 disables refresh.

- `I_CLK`  in  1  system clock; all logic on rising edge.
- `I_RSTF`  in  1  reset, synchronous, active-low.
- `I_REQ`  in  N_REQ  per-requester single-cycle request strobe.
- `I_REQ_DATA`  in  32*N_REQ  requester i data in bits [32i+31:32i]; sampled when `I_REQ[i]`=1.
- `O_GNT`  out  N_REQ  one-hot single-cycle pulse when requester i's value is issued.
- `O_REQ_DONE`  out  N_REQ  one-hot single-cycle pulse when requester i's transaction completes normally.
- `O_DROP`  out  N_REQ  single-cycle pulse when a pending value of requester i is overwritten.
- `O_LCD_START`  out  1  single-cycle start to the LCD path.
- `O_LCD_DATA`  out  32  value for the LCD path, held stable from START until the next ISSUE.
- `I_LCD_DONE`  in  1  single-cycle completion from the LCD path.
- `O_SEL`  out  $clog2(N_REQ)  index of the requester last issued.
- `O_BUSY`  out  1  1 whenever the state is not IDLE.
- `O_TIMEOUT`  out  1  sticky; set on any WAIT timeout and cleared only by reset.

## Operation
- Per-requester buffer: `pend[i]` and `pdata[i]`.
  - `I_REQ[i]` sets `pend[i]` and loads `pdata[i]`.
  - If `pend[i]` is already 1, new data overwrites the old value and `O_DROP[i]` pulses; latest value wins.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE, when `pend` != 0:
  - Select the first set bit searching upward, with wrap, from `last+1`.
  - Load `O_LCD_DATA` <= `pdata[sel]` and `O_SEL` <= sel.
  - Go to ISSUE.
- IDLE, refresh:
  - Applies when `pend`=0 and `REFRESH_CYC`!=0.
  - The refresh counter counts IDLE cycles. When it reaches `REFRESH_CYC`, go to ISSUE as a refresh with `O_LCD_DATA` and `O_SEL` unchanged.
  - A refresh produces no `O_GNT`/`O_REQ_DONE` pulses.
  - The counter clears on leaving IDLE and whenever `pend`!=0.
- ISSUE (1 cycle):
  - `O_LCD_START`=1.
  - For a real grant: `O_GNT[sel]`=1, clear `pend[sel]`, set `last`<=sel.
  - Go to WAIT.
- WAIT:
  - `I_LCD_DONE`=1: pulse `O_REQ_DONE[sel]` next cycle (non-refresh only), go to GAP.
  - Timeout counter reaches `TIMEOUT_CYC` with no done: set `O_TIMEOUT`, go to GAP, no `O_REQ_DONE`.
- GAP: hold `GAP_CYC` cycles, then go to IDLE.
- `I_LCD_DONE` outside WAIT is ignored.
- Simultaneous `I_REQ[sel]` in the ISSUE cycle: the clear loses. `pend[sel]` stays 1 with the new data, and `O_DROP` does not pulse.
- Simultaneous requests from several requesters are all buffered, then served in round-robin order.
- Reset mid-transaction:
  - All `pend` cleared, state IDLE, counters 0, `last`=N_REQ-1 (requester 0 has first priority).
  - The LCD path is not notified.

## Timing
- Reset values:
  - All pulse outputs 0; `O_BUSY`=0; `O_TIMEOUT`=0.
  - `O_LCD_DATA`=0; `O_SEL`=0.
- Latency, with `I_REQ[i]` in cycle t and the arbiter IDLE:
  - `pend` visible in t+1 (IDLE selects).
  - ISSUE in t+2: `O_LCD_START`=`O_GNT[i]`=1, `O_LCD_DATA` valid.
- Done handling: `I_LCD_DONE` in cycle d gives `O_REQ_DONE` in d+1, GAP in d+1..d+GAP_CYC, IDLE in d+GAP_CYC+1.
- Minimum spacing between consecutive `O_LCD_START` pulses: 2 + GAP_CYC + 1 cycles with done arriving the cycle after start.
- Timeout: with no done, the abort fires on the `TIMEOUT_CYC`th WAIT cycle; `O_TIMEOUT`=1 from the next cycle.
- `O_BUSY`, `O_GNT`, `O_LCD_START` and all other outputs are registered.

## Test plan
- Reset, then `I_REQ[2]` with 0x1234ABCD in cycle 5 -> START+`GNT[2]` in cycle 7, `O_LCD_DATA`=0x1234ABCD; done in 10 -> `O_REQ_DONE[2]` in 11, `O_BUSY`=0 in 13 (GAP_CYC=2).
- `I_REQ`=4'b1111 in one cycle with data 0xA0..0xA3 -> grants in order 0,1,2,3, each data matching, no drops.
- Second `I_REQ[1]` 0x22 while 0x11 is pending and requester 0 is busy -> `O_DROP[1]` pulse, later issue carries 0x22; a request in the ISSUE cycle of requester 1 -> re-issued later, no drop.
- LCD model never returns done, TIMEOUT_CYC=16 -> `O_TIMEOUT` sets after 16 WAIT cycles, no `O_REQ_DONE`, next pending request still served.
- REFRESH_CYC=20, no requests after a completed transaction -> START with the same data/`O_SEL` after 20 IDLE cycles, no `O_GNT`; a request arriving before then cancels the refresh.
- `I_RSTF` low for one cycle in WAIT with `pend`=4'b0110 -> all outputs at reset values, no grants until new requests.
